// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port byte-addressed data RAM.
// Each access takes one ACCESS cycle followed by a one-cycle response in IDLE.
module ram_arbiter #(
   parameter int unsigned RAM_BYTES = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [2:0]  m0_ubhw,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [2:0]  m1_ubhw,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_din,
   output logic        ram_we,
   output logic [2:0]  ram_ubhw,
   input  logic [31:0] ram_dout
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t      state_reg, state_next;
   logic        ptr_reg, ptr_next;        // id of the requester granted last
   logic        winner_reg, winner_next;
   logic        held_we_reg, held_we_next;
   logic [31:0] held_addr_reg, held_addr_next;
   logic [31:0] held_wdata_reg, held_wdata_next;
   logic [2:0]  held_ubhw_reg, held_ubhw_next;

   logic [1:0]  req_vec;
   logic [1:0]  gnt_vec;
   logic        win_sel;
   logic        access;
   logic        access_err;
   logic [31:0] load_data;

   assign req_vec = {m1_req, m0_req};
   assign win_sel = (req_vec == 2'b11) ? ~ptr_reg : req_vec[1];
   assign access  = (state_reg == ACCESS);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         ptr_reg        <= 1'b1;
         winner_reg     <= 1'b0;
         held_we_reg    <= 1'b0;
         held_addr_reg  <= '0;
         held_wdata_reg <= '0;
         held_ubhw_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         ptr_reg        <= ptr_next;
         winner_reg     <= winner_next;
         held_we_reg    <= held_we_next;
         held_addr_reg  <= held_addr_next;
         held_wdata_reg <= held_wdata_next;
         held_ubhw_reg  <= held_ubhw_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      ptr_next        = ptr_reg;
      winner_next     = winner_reg;
      held_we_next    = held_we_reg;
      held_addr_next  = held_addr_reg;
      held_wdata_next = held_wdata_reg;
      held_ubhw_next  = held_ubhw_reg;
      case (state_reg)
         IDLE: begin
            if (|req_vec) begin
               state_next      = ACCESS;
               winner_next     = win_sel;
               ptr_next        = win_sel;
               held_we_next    = win_sel ? m1_we    : m0_we;
               held_addr_next  = win_sel ? m1_addr  : m0_addr;
               held_wdata_next = win_sel ? m1_wdata : m0_wdata;
               held_ubhw_next  = win_sel ? m1_ubhw  : m0_ubhw;
            end
         end
         ACCESS: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Reserved size code, misalignment for the selected size, or out of range.
   always_comb begin
      access_err = 1'b0;
      if (held_ubhw_reg[1:0] == 2'b11)
         access_err = 1'b1;
      else if (held_ubhw_reg[1:0] == 2'b01 && held_addr_reg[0])
         access_err = 1'b1;
      else if (held_ubhw_reg[1:0] == 2'b10 && held_addr_reg[1:0] != 2'b00)
         access_err = 1'b1;
      if (held_addr_reg >= 32'(RAM_BYTES))
         access_err = 1'b1;
      access_err = access_err & access;
   end

   assign ram_addr  = access ? held_addr_reg  : '0;
   assign ram_din   = access ? held_wdata_reg : '0;
   assign ram_ubhw  = access ? held_ubhw_reg  : '0;
   // rst gates the write directly so a reset during ACCESS blocks the negedge write.
   assign ram_we    = access & held_we_reg & ~access_err & ~rst;
   assign load_data = (access_err | held_we_reg) ? '0 : ram_dout;

   for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      logic        capture;
      logic        rvalid_reg;
      logic [31:0] rdata_reg;
      logic        err_reg;

      assign capture     = access & (winner_reg == 1'(gi));
      assign gnt_vec[gi] = capture;

      always_ff @(posedge clk) begin
         if (rst) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
         end else begin
            rvalid_reg <= capture;
            rdata_reg  <= capture ? load_data : '0;
            err_reg    <= capture & access_err;
         end
      end
   end

   assign m0_gnt    = gnt_vec[0];
   assign m1_gnt    = gnt_vec[1];
   assign m0_rvalid = g_resp[0].rvalid_reg;
   assign m1_rvalid = g_resp[1].rvalid_reg;
   assign m0_rdata  = g_resp[0].rdata_reg;
   assign m1_rdata  = g_resp[1].rdata_reg;
   assign m0_err    = g_resp[0].err_reg;
   assign m1_err    = g_resp[1].err_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a 128-byte little-endian RAM model
// (negedge write, combinational sign/zero-extending read).
module tb_ram_arbiter;

   logic        clk;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [2:0]  m0_ubhw, m1_ubhw;
   logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] ram_addr, ram_din, ram_dout;
   logic        ram_we;
   logic [2:0]  ram_ubhw;

   int n_cmp = 0;
   int n_bad = 0;
   int wr_count = 0;

   logic [7:0] mem [128];
   logic [6:0] ra;
   logic [7:0] b0, b1, b2, b3;

   ram_arbiter #(.RAM_BYTES(128)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ubhw(m0_ubhw),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ubhw(m1_ubhw),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_ubhw(ram_ubhw),
      .ram_dout(ram_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      ra = ram_addr[6:0];
      b0 = mem[ra];
      b1 = mem[ra + 7'd1];
      b2 = mem[ra + 7'd2];
      b3 = mem[ra + 7'd3];
      case (ram_ubhw[1:0])
         2'b00:   ram_dout = ram_ubhw[2] ? {24'h0, b0} : {{24{b0[7]}}, b0};
         2'b01:   ram_dout = ram_ubhw[2] ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
         default: ram_dout = {b3, b2, b1, b0};
      endcase
   end

   always @(negedge clk) begin
      if (ram_we) begin
         wr_count <= wr_count + 1;
         mem[ra] <= ram_din[7:0];
         if (ram_ubhw[1:0] != 2'b00) mem[ra + 7'd1] <= ram_din[15:8];
         if (ram_ubhw[1:0] == 2'b10) begin
            mem[ra + 7'd2] <= ram_din[23:16];
            mem[ra + 7'd3] <= ram_din[31:24];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Starts from an IDLE cycle (#1 after posedge), ends #1 after the rvalid posedge.
   task automatic do_access(input string tag, input int m, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] ubhw, input logic [31:0] exp_rdata,
                            input logic exp_err);
      int wr0;
      logic exp_we;
      exp_we = we & ~exp_err;
      wr0 = wr_count;
      if (m == 0) begin
         m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_ubhw = ubhw;
      end else begin
         m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_ubhw = ubhw;
      end
      @(posedge clk); #1;
      check({tag, " gnt"}, 32'(m == 0 ? m0_gnt : m1_gnt), 32'd1);
      check({tag, " other gnt"}, 32'(m == 0 ? m1_gnt : m0_gnt), 32'd0);
      check({tag, " ram_we"}, 32'(ram_we), 32'(exp_we));
      check({tag, " ram_addr"}, ram_addr, addr);
      m0_req = 1'b0;
      m1_req = 1'b0;
      @(posedge clk); #1;
      $display("access %s: m%0d we=%0d addr=%h ubhw=%b rvalid=%0d rdata=%h err=%0d",
               tag, m, we, addr, ubhw, m == 0 ? m0_rvalid : m1_rvalid,
               m == 0 ? m0_rdata : m1_rdata, m == 0 ? m0_err : m1_err);
      check({tag, " rvalid"}, 32'(m == 0 ? m0_rvalid : m1_rvalid), 32'd1);
      check({tag, " other rvalid"}, 32'(m == 0 ? m1_rvalid : m0_rvalid), 32'd0);
      check({tag, " rdata"}, m == 0 ? m0_rdata : m1_rdata, exp_rdata);
      check({tag, " err"}, 32'(m == 0 ? m0_err : m1_err), 32'(exp_err));
      check({tag, " gnt low"}, 32'(m == 0 ? m0_gnt : m1_gnt), 32'd0);
      check({tag, " writes"}, 32'(wr_count - wr0), 32'(exp_we));
   endtask

   logic [3:0] rr_exp [8] = '{4'b0100, 4'b0001, 4'b1000, 4'b0010,
                              4'b0100, 4'b0001, 4'b1000, 4'b0010};

   initial begin
      int wr0;
      rst = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_ubhw = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_ubhw = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset gnt", {30'h0, m1_gnt, m0_gnt}, 32'd0);
      check("reset rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'd0);
      check("reset err", {30'h0, m1_err, m0_err}, 32'd0);
      check("reset rdata0", m0_rdata, 32'd0);
      check("reset ram_we", 32'(ram_we), 32'd0);
      check("reset ram_addr", ram_addr, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      do_access("st_w",   0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
      do_access("ld_w",   0, 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0);
      do_access("st_b",   1, 1'b1, 32'h10, 32'h00000080, 3'b000, 32'h0, 1'b0);
      do_access("ld_bs",  1, 1'b0, 32'h10, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0);
      do_access("ld_bu",  0, 1'b0, 32'h10, 32'h0,        3'b100, 32'h00000080, 1'b0);
      do_access("ld_hs",  0, 1'b0, 32'h10, 32'h0,        3'b001, 32'hFFFFBE80, 1'b0);
      do_access("er_w12", 0, 1'b1, 32'h12, 32'h11111111, 3'b010, 32'h0, 1'b1);
      do_access("er_h11", 1, 1'b1, 32'h11, 32'h2222,     3'b001, 32'h0, 1'b1);
      do_access("er_b80", 0, 1'b1, 32'h80, 32'h33,       3'b000, 32'h0, 1'b1);
      do_access("er_011", 1, 1'b1, 32'h10, 32'h44444444, 3'b011, 32'h0, 1'b1);
      do_access("ld_chk", 1, 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBE80, 1'b0);

      // Both requesters hold requests; m1 was granted last so m0 wins first.
      m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_ubhw = 3'b010;
      m1_req = 1; m1_we = 0; m1_addr = 32'h14; m1_ubhw = 3'b010;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         $display("rr cycle %0d: gnt=%b%b rvalid=%b%b", k, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid);
         check($sformatf("rr cycle %0d", k), {28'h0, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid},
               {28'h0, rr_exp[k]});
         if (rr_exp[k] == 4'b0001) check("rr m0 rdata", m0_rdata, 32'hDEADBE80);
      end
      m0_req = 0;
      m1_req = 0;

      // A request pulse that never spans a posedge is ignored.
      @(posedge clk); #1;
      m1_req = 1; m1_we = 1; m1_addr = 32'h10; m1_wdata = 32'h99; m1_ubhw = 3'b000;
      #2 m1_req = 0;
      @(posedge clk); #1;
      $display("glitch req: gnt=%b%b ram_we=%0d", m1_gnt, m0_gnt, ram_we);
      check("glitch gnt", {30'h0, m1_gnt, m0_gnt}, 32'd0);
      check("glitch ram_we", 32'(ram_we), 32'd0);

      // Reset during the ACCESS cycle of a store aborts it.
      wr0 = wr_count;
      m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'h55; m0_ubhw = 3'b000;
      @(posedge clk); #1;
      check("abort gnt", 32'(m0_gnt), 32'd1);
      rst = 1'b1;
      m0_req = 0;
      #1;
      check("abort ram_we", 32'(ram_we), 32'd0);
      @(posedge clk); #1;
      $display("abort: rvalid=%b%b writes=%0d", m1_rvalid, m0_rvalid, wr_count - wr0);
      check("abort rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort writes", 32'(wr_count - wr0), 32'd0);
      check("abort mem", {24'h0, mem[7'h10]}, 32'h80);

      m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_ubhw = 3'b100;
      m1_req = 1; m1_we = 0; m1_addr = 32'h14; m1_ubhw = 3'b010;
      @(posedge clk); #1;
      $display("post-reset tie: gnt=%b%b", m1_gnt, m0_gnt);
      check("tie after reset", {30'h0, m1_gnt, m0_gnt}, 32'd1);
      m0_req = 0;
      m1_req = 0;
      @(posedge clk); #1;
      check("tie rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'd1);
      check("tie rdata", m0_rdata, 32'h00000080);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
